// File: rtl/pwm_duty_meter_if.sv
// Signal bundle between the PWM duty meter and its user: the measured PWM line in,
// the duty result and the multiplexed 7-segment display out.
interface pwm_duty_meter_if;
    logic       senal_in;
    logic [6:0] duty;
    logic       valid;
    logic       timeout;
    logic [7:0] catodos;
    logic [3:0] anodos;

    modport master (
        input  senal_in,
        output duty, valid, timeout, catodos, anodos
    );

    modport slave (
        output senal_in,
        input  duty, valid, timeout, catodos, anodos
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an external PWM line and reports the duty cycle
// in integer percent, both as a register output and on a 4-digit 7-segment display.
module pwm_duty_meter #(
    parameter int CNT_W   = 20,
    parameter int MUX_DIV = 100000
) (
    input logic              clk,
    input logic              rst,
    pwm_duty_meter_if.master bus
);
    localparam int NUM_W  = CNT_W + 7;
    localparam int STEP_W = $clog2(NUM_W);
    localparam int MUX_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W - 1);
    localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_DIV - 1);

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_e;

    logic              s_meta_q, s_meta_d;
    logic              s_sync_q, s_sync_d;
    logic              s_dly_q, s_dly_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic              armed_q, armed_d;
    logic              timeout_q, timeout_d;
    logic [6:0]        duty_q, duty_d;
    logic              valid_q, valid_d;
    div_state_e        div_state_q, div_state_d;
    logic [CNT_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [MUX_W-1:0]  mux_cnt_q, mux_cnt_d;
    logic [1:0]        digit_q, digit_d;

    logic              rise;
    logic              timeout_hit;
    logic [CNT_W:0]    shifted;
    logic              div_ge;
    logic [CNT_W-1:0]  rem_next;
    logic [NUM_W-1:0]  quo_next;
    logic [6:0]        quo_clamped;

    assign rise        = s_sync_q & ~s_dly_q;
    assign timeout_hit = !rise && (period_cnt_q == CNT_MAX) && !timeout_q;

    // One restoring-division step: bring down the next numerator bit, subtract if it fits.
    assign shifted     = {rem_q, quo_q[NUM_W-1]};
    assign div_ge      = shifted >= {1'b0, divisor_q};
    assign rem_next    = div_ge ? (shifted[CNT_W-1:0] - divisor_q) : shifted[CNT_W-1:0];
    assign quo_next    = {quo_q[NUM_W-2:0], div_ge};
    assign quo_clamped = (quo_next > NUM_W'(100)) ? 7'd100 : quo_next[6:0];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        s_meta_d     = bus.senal_in;
        s_sync_d     = s_meta_q;
        s_dly_d      = s_sync_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        armed_d      = armed_q;
        timeout_d    = timeout_q;
        duty_d       = duty_q;
        valid_d      = 1'b0;
        div_state_d  = div_state_q;
        divisor_d    = divisor_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        mux_cnt_d    = mux_cnt_q;
        digit_d      = digit_q;

        if (rise) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
        end else begin
            if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + CNT_W'(1);
            if (s_sync_q && (high_cnt_q != CNT_MAX)) high_cnt_d = high_cnt_q + CNT_W'(1);
        end

        if (timeout_hit) begin
            timeout_d   = 1'b1;
            armed_d     = 1'b0;
            duty_d      = s_sync_q ? 7'd100 : 7'd0;
            valid_d     = 1'b1;
            div_state_d = DIV_IDLE;
        end else begin
            if (rise) begin
                timeout_d = 1'b0;
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (div_state_q == DIV_IDLE) begin
                    divisor_d   = period_cnt_q;
                    rem_d       = '0;
                    quo_d       = NUM_W'(high_cnt_q) * NUM_W'(100);
                    step_d      = STEP_LAST;
                    div_state_d = DIV_RUN;
                end
            end
            if (div_state_q == DIV_RUN) begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (step_q == '0) begin
                    duty_d      = quo_clamped;
                    valid_d     = 1'b1;
                    div_state_d = DIV_IDLE;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
        end

        if (mux_cnt_q == MUX_LAST) begin
            mux_cnt_d = '0;
            digit_d   = digit_q + 2'd1;
        end else begin
            mux_cnt_d = mux_cnt_q + MUX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta_q     <= 1'b0;
            s_sync_q     <= 1'b0;
            s_dly_q      <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            armed_q      <= 1'b0;
            timeout_q    <= 1'b0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            div_state_q  <= DIV_IDLE;
            divisor_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            mux_cnt_q    <= '0;
            digit_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            s_meta_q     <= s_meta_d;
            s_sync_q     <= s_sync_d;
            s_dly_q      <= s_dly_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            armed_q      <= armed_d;
            timeout_q    <= timeout_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            div_state_q  <= div_state_d;
            divisor_q    <= divisor_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            mux_cnt_q    <= mux_cnt_d;
            digit_q      <= digit_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic       hundreds;
    logic [6:0] below_100;
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] catodos;

    assign hundreds  = duty_q >= 7'd100;
    assign below_100 = hundreds ? (duty_q - 7'd100) : duty_q;
    assign tens      = 4'(below_100 / 7'd10);
    assign units     = 4'(below_100 % 7'd10);

    // Leading-zero blanking; dp (bit 7) stays off on every digit.
    always_comb begin
        catodos = 8'hFF;
        case (digit_q)
            2'd0:    catodos = {1'b1, seg7(units)};
            2'd1:    catodos = (!hundreds && tens == 4'd0) ? 8'hFF : {1'b1, seg7(tens)};
            2'd2:    catodos = hundreds ? {1'b1, seg7(4'd1)} : 8'hFF;
            default: catodos = 8'hFF;
        endcase
    end

    assign bus.duty    = duty_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.catodos = catodos;
    assign bus.anodos  = ~(4'b0001 << digit_q);
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed and randomized checks of pwm_duty_meter against a duty/display reference
// derived from the waveform the bench itself drives.
module tb_pwm_duty_meter;
    localparam int CNT_W   = 12;
    localparam int MUX_DIV = 4;
    localparam int LAT     = 2 + CNT_W + 8;   // input drive -> valid, including the synchronizer
    localparam int TO_WAIT = (1 << CNT_W) + 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_duty_meter_if bus ();

    pwm_duty_meter #(.CNT_W(CNT_W), .MUX_DIV(MUX_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int base     = 0;
    int vq_duty[$];
    int vq_cyc[$];
    int exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.valid === 1'b1) begin
            vq_duty.push_back(int'(bus.duty));
            vq_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_duty(input int high, input int period);
        int d;
        d = (high * 100) / period;
        return (d > 100) ? 100 : d;
    endfunction

    function automatic logic [7:0] exp_cat(input int d, input int pos);
        int h, t, u;
        h = d / 100;
        t = (d / 10) % 10;
        u = d % 10;
        case (pos)
            0:       return {1'b1, seg_tab[u]};
            1:       return (h == 0 && t == 0) ? 8'hFF : {1'b1, seg_tab[t]};
            2:       return (h != 0) ? {1'b1, seg_tab[h]} : 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.senal_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = vq_duty.size();
    endtask

    // Drives n periods starting at a negedge with the line low; each period is high then low.
    task automatic pwm(input int period, input int high, input int n);
        for (int p = 0; p < n; p++) begin
            bus.senal_in = 1'b1;
            rise_cyc = cyc;
            repeat (high) @(negedge clk);
            bus.senal_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    task automatic wait_timeout();
        for (int i = 0; i < TO_WAIT && bus.timeout !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic check_display(input int d, input string tag);
        logic [7:0] seen [4];
        int bad;
        bad = 0;
        for (int p = 0; p < 4; p++) seen[p] = 8'h00;
        for (int k = 0; k < 8 * MUX_DIV; k++) begin
            @(negedge clk);
            case (bus.anodos)
                4'b1110: seen[0] = bus.catodos;
                4'b1101: seen[1] = bus.catodos;
                4'b1011: seen[2] = bus.catodos;
                4'b0111: seen[3] = bus.catodos;
                default: bad++;
            endcase
        end
        check({tag, "_anodo_onehot"}, 32'(bad), 32'd0);
        for (int p = 0; p < 4; p++)
            check($sformatf("%s_digit%0d", tag, p), 32'(seen[p]), 32'(exp_cat(d, p)));
    endtask

    initial begin
        int n, n0, p, h;
        logic [3:0] ea;
        bus.senal_in = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_duty", 32'(bus.duty), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_anodos", 32'(bus.anodos), 32'(4'b1110));
        check("rst_catodos", 32'(bus.catodos), 32'(8'hC0));

        // Digit scan: each anode held MUX_DIV cycles, order 0,1,2,3,0
        rst = 1'b0;
        for (int k = 0; k < 5 * MUX_DIV; k++) begin
            #1;
            ea = ~(4'b0001 << ((k / MUX_DIV) % 4));
            check($sformatf("mux_k%0d", k), 32'(bus.anodos), 32'(ea));
            @(negedge clk);
        end

        // 25% duty: first rise only arms, second captures with fixed latency
        do_reset();
        pwm(1000, 250, 1);
        check("t1_arm_only", 32'(vq_duty.size() - base), 32'd0);
        pwm(1000, 250, 1);
        check("t1_count", 32'(vq_duty.size() - base), 32'd1);
        if (vq_duty.size() > base) begin
            check("t1_duty", 32'(vq_duty[base]), 32'(ref_duty(250, 1000)));
            check("t1_latency", 32'(vq_cyc[base] - rise_cyc), 32'(LAT));
        end
        check_display(25, "t1");

        // Period 3: most captures dropped, every reported value still 33
        do_reset();
        pwm(3, 1, 60);
        repeat (30) @(negedge clk);
        n = vq_duty.size() - base;
        check("t2_any_valid", 32'(int'(n > 0)), 32'd1);
        for (int i = 0; i < n; i++)
            check($sformatf("t2_duty%0d", i), 32'(vq_duty[base + i]), 32'(ref_duty(1, 3)));

        // Held high after one rise: timeout with duty 100
        do_reset();
        bus.senal_in = 1'b1;
        wait_timeout();
        repeat (5) @(negedge clk);
        check("t3_timeout", 32'(bus.timeout), 32'd1);
        check("t3_duty", 32'(bus.duty), 32'd100);
        check("t3_one_valid", 32'(vq_duty.size() - base), 32'd1);
        check_display(100, "t3");
        bus.senal_in = 1'b0;
        repeat (5) @(negedge clk);
        pwm(100, 30, 1);
        check("t3_cleared", 32'(bus.timeout), 32'd0);
        check("t3_rearm_no_valid", 32'(vq_duty.size() - base), 32'd1);
        pwm(100, 30, 1);
        check("t3_count_after", 32'(vq_duty.size() - base), 32'd2);
        if (vq_duty.size() > base + 1)
            check("t3_duty_after", 32'(vq_duty[base + 1]), 32'(ref_duty(30, 100)));

        // Held low: timeout with duty 0
        do_reset();
        wait_timeout();
        repeat (5) @(negedge clk);
        check("t4_timeout", 32'(bus.timeout), 32'd1);
        check("t4_duty", 32'(bus.duty), 32'd0);
        check("t4_one_valid", 32'(vq_duty.size() - base), 32'd1);
        check_display(0, "t4");

        // Reset mid-division aborts the result
        do_reset();
        pwm(200, 100, 3);
        check("t5_pre_duty", 32'(bus.duty), 32'd50);
        bus.senal_in = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_duty", 32'(bus.duty), 32'd0);
        check("t5_rst_valid", 32'(bus.valid), 32'd0);
        check("t5_rst_timeout", 32'(bus.timeout), 32'd0);
        check("t5_rst_anodos", 32'(bus.anodos), 32'(4'b1110));
        check("t5_rst_catodos", 32'(bus.catodos), 32'(8'hC0));
        n0 = vq_duty.size();
        bus.senal_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_no_stale_valid", 32'(vq_duty.size() - n0), 32'd0);
        pwm(200, 100, 2);
        check("t5_count_after", 32'(vq_duty.size() - n0), 32'd1);
        if (vq_duty.size() > n0)
            check("t5_duty_after", 32'(vq_duty[n0]), 32'(ref_duty(100, 200)));

        // Randomized waveforms: every closed period yields its own duty
        do_reset();
        exp_q.delete();
        for (int t = 0; t < 6; t++) begin
            p = $urandom_range(400, 20);
            h = $urandom_range(p - 1, 1);
            pwm(p, h, 3);
            repeat (3) exp_q.push_back(ref_duty(h, p));
        end
        bus.senal_in = 1'b1;
        repeat (40) @(negedge clk);
        bus.senal_in = 1'b0;
        repeat (5) @(negedge clk);
        n = vq_duty.size() - base;
        check("rnd_count", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("rnd_duty%0d", i), 32'(vq_duty[base + i]), 32'(exp_q[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the DPWM generator: samples an external PWM line (e.g. DPWM `senal` looped back), measures period and high time, and computes the duty cycle as integer percent 0..100.
- Shows the result on the same 4-digit multiplexed 7-segment display interface (`catodos`/`anodos`).
- Used on-board to close the loop on the PWM generator and in benches as a checker.

Parameters:
- CNT_W, 20, width of period/high counters; max measurable period is 2^CNT_W-1 cycles.
- MUX_DIV, 100000, clock cycles each display digit is enabled (1 ms at 100 MHz).

Ports:
- clk, input, 1, system clock (100 MHz nominal).
- rst, input, 1, asynchronous active-high reset.
- senal_in, input, 1, PWM line under measurement; asynchronous to clk.
- duty, output, 7, last measured duty in percent, 0..100.
- valid, output, 1, one-cycle pulse when duty updates.
- timeout, output, 1, level; no rising edge seen within 2^CNT_W-1 cycles.
- catodos, output, 8, segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- anodos, output, 4, digit enables, active-low, bit 0 = rightmost.

Behaviour:
- Reset is asynchronous, active-high, and may assert at any time. It clears all state, aborts any in-progress division, and forces the following values:
  - duty = 0, valid = 0, timeout = 0.
  - anodos = 4'b1110, catodos = 8'b1100_0000 (digit 0 showing '0').
  - Internal: armed = 0, divider idle, mux counter = 0.
- Input synchronizer and edge detect:
  - senal_in passes through a 2-FF synchronizer giving s_sync.
  - rise = s_sync & ~s_sync_d. One further register provides s_sync_d.
- Counters:
  - On a rise cycle: period_cnt <= 1 and high_cnt <= 1.
  - On any other cycle: period_cnt increments; high_cnt increments when s_sync = 1.
  - Both counters saturate at 2^CNT_W-1.
- Capture:
  - On rise with armed = 1 and divider idle: P = period_cnt and H = high_cnt (values before reload).
    - P = cycles from the previous rise (inclusive) to this rise (exclusive).
    - H = high cycles within that window.
  - First rise after reset or after a timeout sets armed = 1 and captures nothing.
  - A rise while the divider is busy does not capture (measurement dropped), but the counters still reload.
- Divider:
  - Sequential restoring division computing floor(H*100/P). Numerator width CNT_W+7.
  - Takes exactly CNT_W+7 iteration cycles.
  - duty and valid update exactly CNT_W+8 cycles after the capture cycle.
  - Result is clamped to 100.
- Timeout:
  - Triggers when period_cnt reaches 2^CNT_W-1 with armed = 1 or 0 and no rise has occurred.
  - Effects: timeout <= 1 and armed <= 0. duty <= 100 if s_sync = 1, else 0. valid pulses once.
  - Any in-progress division is aborted.
  - timeout stays high until the next rise, which clears it and re-arms.
- Display:
  - duty is converted to BCD hundreds/tens/units. The conversion is combinational or registered; either way it settles before the next digit switch.
  - Digit 0 = units (always shown).
  - Digit 1 = tens, blank when hundreds = 0 and tens = 0.
  - Digit 2 = hundreds, blank when 0.
  - Digit 3 always blank.
  - Blank = 8'hFF; dp is always off.
  - Digit scan order is 0,1,2,3,0…; anodos advances every MUX_DIV cycles; exactly one anodo bit is low at a time.
  - Patterns (active-low, g..a):
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
    - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

Test Plan:
1. senal_in period 1000 cycles, 250 high, from reset → first rise arms only; after the second rise, duty = 25 with valid pulse at capture+28. Display: digit0 = 0010010 ('5'), digit1 = 0100100 ('2'), digit2/3 = 8'hFF.
2. Period 3, high 1 (CNT_W=20) → rises every 3 cycles, divider busy 27 cycles so most captures drop. Every valid shows duty = 33, never another value.
3. senal_in held high after one rise → at period_cnt = 2^20-1: timeout = 1, duty = 100, one valid pulse. Display shows '1','0','0' on digits 2..0. Restarting the PWM clears timeout on the first rise; the next valid appears only after the second rise.
4. senal_in held low → timeout = 1, duty = 0; digit0 shows '0', digits 1–3 blank.
5. Reset asserted mid-division of a 50% waveform (period 200) → outputs immediately return to reset values and no valid pulse comes from the aborted division. After release, the first rise arms and the second yields duty = 50.
6. Display mux with MUX_DIV = 4 → anodos sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.
